// File: rtl/char_serializer_if.sv
// Character handshake and serial-line bundle between the pattern encoder and
// the char_serializer stage.
`timescale 1ns/1ps
interface char_serializer_if;
  logic [6:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  modport master (
    output char_in,
    output char_valid,
    input  char_ready,
    input  tx_out,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready,
    output tx_out,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/char_serializer.sv
// Serialises 7-bit ASCII characters into start / 7 data (LSB first) /
// optional even parity / stop frames, each bit held CLKS_PER_BIT cycles.
`timescale 1ns/1ps
module char_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  char_serializer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  function automatic logic even_parity(input logic [6:0] c);
    return ^c;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [6:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        accept_s;
  logic        last_s;

  assign bus.char_ready = (state_q == IDLE) && RST_N;
  assign accept_s       = bus.char_valid && bus.char_ready;
  assign last_s         = (cnt_q == LAST_CNT);

  // tx_d always reflects the level of the state being entered, so the line is
  // a pure register output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept_s) begin
          state_d = START;
          shift_d = bus.char_in;
          par_d   = even_parity(bus.char_in);
          cnt_d   = 16'd0;
          tx_d    = 1'b0;
        end else begin
          cnt_d = 16'd0;
        end
      end
      START: begin
        if (last_s) begin
          state_d = DATA;
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (last_s) begin
          cnt_d = 16'd0;
          if (bit_q == 3'd6) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[6:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PARITY: begin
        if (last_s) begin
          state_d = STOP;
          cnt_d   = 16'd0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (last_s) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 7'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_out     = tx_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_char_serializer.sv
// Bench for char_serializer: dut_a (4 clocks/bit, parity) and dut_b
// (1 clock/bit, no parity) share clock and reset.
`timescale 1ns/1ps
module tb_char_serializer;

  logic CLK = 1'b0;
  logic RST_N;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 CLK = ~CLK;

  char_serializer_if ifa();
  char_serializer_if ifb();

  char_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ifa));
  char_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ifb));

  typedef struct {
    int         which;
    logic [6:0] ch;
    logic [9:0] frame;   // bit i = i-th bit on the line: start, d0..d6, parity, stop
    bit         hold;
    bit         noise;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Frame as seen on the line, from the framing rules.
  function automatic logic [9:0] model_frame(input logic [6:0] c);
    int   ones;
    logic p;
    ones = $countones(c);
    p    = (ones % 2 == 1) ? 1'b1 : 1'b0;
    return {1'b1, p, c, 1'b0};
  endfunction

  function automatic logic tx_of(input int w);
    return (w == 0) ? ifa.tx_out : ifb.tx_out;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? ifa.busy : ifb.busy;
  endfunction
  function automatic logic ready_of(input int w);
    return (w == 0) ? ifa.char_ready : ifb.char_ready;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? ifa.frame_done : ifb.frame_done;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [6:0] c);
    if (w == 0) begin
      ifa.char_valid = v;
      ifa.char_in    = c;
    end else begin
      ifb.char_valid = v;
      ifb.char_in    = c;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Offers ch and returns 1 ns after the accept edge E0.
  task automatic wait_accept(input int w, input logic [6:0] c, output bit ok);
    int n;
    ok = 1'b0;
    set_in(w, 1'b1, c);
    @(negedge CLK);
    n = 0;
    while (!ready_of(w) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!ready_of(w)) begin
      chk("ready_timeout", 1'b0, 1'b1);
    end else begin
      @(posedge CLK);
      #1;
      ok = 1'b1;
    end
  endtask

  // Checks every cycle of one frame and the frame_done cycle after it.
  task automatic run_frame(input int w, input logic [6:0] c, input logic [9:0] bits,
                           input bit hold, input bit noise);
    int cpb, n, idx;
    bit par, ok;
    cpb = (w == 0) ? 4 : 1;
    par = (w == 0);
    n   = (par ? 10 : 9) * cpb;
    wait_accept(w, c, ok);
    if (ok) begin
      if (!hold) set_in(w, 1'b0, c);
      for (int t = 0; t < n; t++) begin
        idx = t / cpb;
        if (!par && idx == 8) idx = 9;
        chk("tx_bit", tx_of(w), bits[idx]);
        chk("busy_in_frame", busy_of(w), 1'b1);
        chk("ready_in_frame", ready_of(w), 1'b0);
        chk("done_in_frame", done_of(w), 1'b0);
        if (noise && t == n / 2) set_in(w, 1'b1, 7'h41);
        @(posedge CLK);
        #1;
      end
      chk("tx_done_cycle", tx_of(w), 1'b1);
      chk("busy_done_cycle", busy_of(w), 1'b0);
      chk("ready_done_cycle", ready_of(w), 1'b1);
      chk("frame_done", done_of(w), 1'b1);
      if (noise) set_in(w, 1'b0, 7'h41);
    end
  endtask

  initial begin
    bit         ok;
    int         w;
    logic [6:0] c;

    RST_N = 1'b0;
    set_in(0, 1'b0, 7'h00);
    set_in(1, 1'b0, 7'h00);

    vecs.push_back('{0, 7'h52, 10'h3A4, 1'b0, 1'b0});
    vecs.push_back('{0, 7'h52, 10'h3A4, 1'b0, 1'b1});
    vecs.push_back('{0, 7'h79, 10'h3F2, 1'b1, 1'b0});
    vecs.push_back('{0, 7'h79, 10'h3F2, 1'b1, 1'b0});
    vecs.push_back('{0, 7'h79, 10'h3F2, 1'b0, 1'b0});
    vecs.push_back('{0, 7'h00, 10'h200, 1'b0, 1'b0});
    vecs.push_back('{0, 7'h7F, 10'h3FE, 1'b0, 1'b0});
    vecs.push_back('{0, 7'h41, 10'h282, 1'b0, 1'b0});
    vecs.push_back('{1, 7'h4B, 10'h296, 1'b0, 1'b0});
    vecs.push_back('{1, 7'h7F, 10'h3FE, 1'b0, 1'b0});
    vecs.push_back('{1, 7'h00, 10'h200, 1'b0, 1'b0});

    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_tx", tx_of(k), 1'b1);
      chk("rst_busy", busy_of(k), 1'b0);
      chk("rst_ready", ready_of(k), 1'b0);
      chk("rst_done", done_of(k), 1'b0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("ready_after_release_a", ready_of(0), 1'b1);
    chk("ready_after_release_b", ready_of(1), 1'b1);

    foreach (vecs[i]) begin
      run_frame(vecs[i].which, vecs[i].ch, vecs[i].frame, vecs[i].hold, vecs[i].noise);
    end

    // No valid in IDLE: line stays high, nothing starts.
    repeat (5) begin
      @(posedge CLK);
      #1;
      chk("idle_tx", tx_of(0), 1'b1);
      chk("idle_busy", busy_of(0), 1'b0);
    end

    // Reset during data bit 3 of 'R'.
    wait_accept(0, 7'h52, ok);
    if (ok) begin
      set_in(0, 1'b0, 7'h52);
      repeat (17) @(posedge CLK);
      #1;
      chk("bit3_before_reset", tx_of(0), 1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      chk("midreset_tx", tx_of(0), 1'b1);
      chk("midreset_busy", busy_of(0), 1'b0);
      chk("midreset_ready", ready_of(0), 1'b0);
      repeat (3) begin
        @(posedge CLK);
        #1;
        chk("midreset_no_done", done_of(0), 1'b0);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      chk("ready_after_midreset", ready_of(0), 1'b1);
      run_frame(0, 7'h4B, 10'h296, 1'b0, 1'b0);
    end

    for (int r = 0; r < 24; r++) begin
      w = int'($urandom_range(0, 1));
      c = 7'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      run_frame(w, c, model_frame(c), 1'b0, 1'b0);
    end

    @(posedge CLK);
    #1;
    chk("final_tx_a", tx_of(0), 1'b1);
    chk("final_tx_b", tx_of(1), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
